// File: rtl/inst_pkg.sv
// Instruction-field encodings shared by the core's decoder and the program loader.
package inst_pkg;

    localparam logic [1:0] OP_CODE_DP  = 2'b00;
    localparam logic [1:0] OP_CODE_MEM = 2'b01;
    localparam logic [1:0] OP_CODE_B   = 2'b10;

    localparam logic [3:0] FUNCT_4_1_ADD = 4'b0100;
    localparam logic [3:0] FUNCT_4_1_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_4_1_AND = 4'b0000;
    localparam logic [3:0] FUNCT_4_1_ORR = 4'b1100;

    localparam logic       FUNCT_0_LDR    = 1'b1;
    localparam logic       FUNCT_0_STR    = 1'b0;
    localparam logic       FUNCT_5_DP_REG = 1'b0;
    localparam logic [1:0] FUNCT_5_4_B    = 2'b10;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_packer.sv
// Packs decoded fields into a 32-bit ARM-subset word and flags encodings the core
// cannot execute. Purely combinational.
module instr_packer
    import inst_pkg::*;
(
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [23:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = {cond, op, funct, rn, rd, imm[11:0]};
        illegal = 1'b0;
        case (op)
            OP_CODE_DP: begin
                if (!(funct[4:1] inside {FUNCT_4_1_ADD, FUNCT_4_1_SUB,
                                         FUNCT_4_1_AND, FUNCT_4_1_ORR}))
                    illegal = 1'b1;
            end
            OP_CODE_MEM: begin
                illegal = 1'b0;
            end
            OP_CODE_B: begin
                // Branch keeps only the link/type bits of funct; the offset takes the rest.
                word = {cond, OP_CODE_B, funct[5:4], imm};
                if (funct[5:4] != FUNCT_5_4_B)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (cond == COND_NV)
            illegal = 1'b1;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams decoded instruction fields into instruction memory as encoded words,
// one session at a time, starting from a programmable word-aligned base.
module instr_encoder_loader
    import inst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       finish,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_cond,
    input  logic [1:0]                 in_op,
    input  logic [5:0]                 in_funct,
    input  logic [3:0]                 in_rn,
    input  logic [3:0]                 in_rd,
    input  logic [23:0]                in_imm,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH+1)-1:0] word_count
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    loader_state_e     state;
    logic [ADDR_W-1:0] addr_nxt_p0;
    logic [CW-1:0]     count_q;
    logic              err_q;
    logic [31:0]       word_p0;
    logic              illegal_p0;
    logic              accept_p0;
    logic              legal_wr_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [31:0]       word_p1;

    instr_packer u_packer (
        .cond    (in_cond),
        .op      (in_op),
        .funct   (in_funct),
        .rn      (in_rn),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (word_p0),
        .illegal (illegal_p0)
    );

    // Stage p0: the beat is encoded combinationally and accepted against the word budget.
    assign in_ready    = (state == ST_RUN) && (count_q < FULL);
    assign accept_p0   = in_valid && in_ready;
    assign legal_wr_p0 = accept_p0 && !illegal_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_nxt_p0 <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            vld_p1      <= 1'b0;
            addr_p1     <= '0;
            word_p1     <= '0;
        end else begin
            // Stage p1: registered write; address and data hold between strobes.
            vld_p1 <= legal_wr_p0;
            if (legal_wr_p0) begin
                word_p1     <= word_p0;
                addr_p1     <= addr_nxt_p0;
                addr_nxt_p0 <= addr_nxt_p0 + ADDR_W'(4);
                count_q     <= count_q + CW'(1);
            end
            if (accept_p0 && illegal_p0)
                err_q <= 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        addr_nxt_p0 <= {base_addr[ADDR_W-1:2], 2'b00};
                        count_q     <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // A beat arriving with finish is taken before the session closes.
                    if (finish || (legal_wr_p0 && count_q == LAST))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign imem_we    = vld_p1;
    assign imem_addr  = addr_p1;
    assign imem_wdata = word_p1;
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign err        = err_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a default instance, a DEPTH=4 instance and an
// ADDR_W=8 instance share one stimulus stream; sel picks the instance under check.
module tb_instr_encoder_loader;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, finish, in_valid;
    logic [31:0] base_addr;
    logic [3:0]  in_cond, in_rn, in_rd;
    logic [1:0]  in_op;
    logic [5:0]  in_funct;
    logic [23:0] in_imm;

    logic        m_ready, m_we, m_busy, m_done, m_err;
    logic [31:0] m_addr, m_wdata;
    logic [6:0]  m_count;
    logic        c_ready, c_we, c_busy, c_done, c_err;
    logic [31:0] c_addr, c_wdata;
    logic [2:0]  c_count;
    logic        w_ready, w_we, w_busy, w_done, w_err;
    logic [7:0]  w_addr;
    logic [31:0] w_wdata;
    logic [6:0]  w_count;

    logic        s_ready, s_busy, s_done, s_err;
    logic [6:0]  s_count;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          sel = 0;
    logic [31:0] exp_addr = '0;
    exp_t        q_main[$];
    exp_t        q_cap[$];
    exp_t        q_wrap[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder_loader #(.ADDR_W(32), .DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(m_ready), .in_cond(in_cond), .in_op(in_op),
        .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata), .busy(m_busy),
        .done(m_done), .err(m_err), .word_count(m_count)
    );

    instr_encoder_loader #(.ADDR_W(32), .DEPTH(4)) dut_cap (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
        .in_valid(in_valid), .in_ready(c_ready), .in_cond(in_cond), .in_op(in_op),
        .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(c_we), .imem_addr(c_addr), .imem_wdata(c_wdata), .busy(c_busy),
        .done(c_done), .err(c_err), .word_count(c_count)
    );

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(64)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[7:0]), .finish(finish),
        .in_valid(in_valid), .in_ready(w_ready), .in_cond(in_cond), .in_op(in_op),
        .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(w_we), .imem_addr(w_addr), .imem_wdata(w_wdata), .busy(w_busy),
        .done(w_done), .err(w_err), .word_count(w_count)
    );

    always_comb begin
        s_ready = m_ready; s_busy = m_busy; s_done = m_done; s_err = m_err; s_count = m_count;
        if (sel == 1) begin
            s_ready = c_ready; s_busy = c_busy; s_done = c_done; s_err = c_err;
            s_count = {4'b0, c_count};
        end else if (sel == 2) begin
            s_ready = w_ready; s_busy = w_busy; s_done = w_done; s_err = w_err; s_count = w_count;
        end
    end

    // Write monitor: every strobe of the instance under check must match the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic        we;
        logic [31:0] addr, data;
        we = 1'b0; addr = '0; data = '0;
        if (sel == 0) begin we = m_we; addr = m_addr; data = m_wdata; end
        if (sel == 1) begin we = c_we; addr = c_addr; data = c_wdata; end
        if (sel == 2) begin we = w_we; addr = {24'b0, w_addr}; data = w_wdata; end
        if (we) begin
            checks++;
            if ((sel == 0 && q_main.size() == 0) || (sel == 1 && q_cap.size() == 0) ||
                (sel == 2 && q_wrap.size() == 0)) begin
                failures++;
                $display("FAIL unexpected_write dut=%0d addr=%h data=%h required=no write", sel, addr, data);
            end else begin
                if (sel == 0) e = q_main.pop_front();
                else if (sel == 1) e = q_cap.pop_front();
                else e = q_wrap.pop_front();
                if (addr !== e.addr || data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write dut=%0d got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                             sel, addr, data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic push_exp(input logic [31:0] w);
        exp_t e;
        e.cyc  = cyc + 1;
        e.addr = (sel == 2) ? {24'b0, exp_addr[7:0]} : exp_addr;
        e.data = w;
        if (sel == 0) q_main.push_back(e);
        else if (sel == 1) q_cap.push_back(e);
        else q_wrap.push_back(e);
        exp_addr = exp_addr + 32'd4;
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] n, input logic [3:0] d, input logic [23:0] imm,
                        input bit wr, input logic [31:0] w, input bit fin);
        int k;
        in_valid = 1'b1; in_cond = c; in_op = o; in_funct = f;
        in_rn = n; in_rd = d; in_imm = imm; finish = fin;
        k = 0;
        @(negedge clk);
        while (!s_ready && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (!s_ready) begin
            failures++;
            $display("FAIL accept_timeout in_ready=%b required=1", s_ready);
        end else if (wr) begin
            push_exp(w);
        end
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic start_session(input logic [31:0] b);
        start = 1'b1; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = {b[31:2], 2'b00};
        checks++;
        if (s_busy !== 1'b1 || s_done !== 1'b0 || s_err !== 1'b0 || s_count !== 7'd0) begin
            failures++;
            $display("FAIL start_state busy=%b done=%b err=%b count=%0d required 1 0 0 0",
                     s_busy, s_done, s_err, s_count);
        end
    endtask

    task automatic finish_pulse();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!s_done && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (!s_done) begin
            failures++;
            $display("FAIL %s_done done=%b required=1", nm, s_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_end(input string nm, input logic [6:0] cnt, input logic e);
        int left;
        left = (sel == 0) ? q_main.size() : (sel == 1) ? q_cap.size() : q_wrap.size();
        checks++;
        if (s_count !== cnt || s_err !== e || s_busy !== 1'b0 || left != 0) begin
            failures++;
            $display("FAIL %s_end count=%0d err=%b busy=%b pending=%0d required count=%0d err=%b busy=0 pending=0",
                     nm, s_count, s_err, s_busy, left, cnt, e);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; base_addr = '0;
        in_cond = '0; in_op = '0; in_funct = '0; in_rn = '0; in_rd = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_we, m_addr, m_wdata, m_busy, m_done, m_err, m_count, m_ready} !== '0) begin
            failures++;
            $display("FAIL reset_outputs we=%b addr=%h data=%h busy=%b done=%b err=%b count=%0d ready=%b required all 0",
                     m_we, m_addr, m_wdata, m_busy, m_done, m_err, m_count, m_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_legal_mix();
        sel = 0;
        start_session(32'h100);
        send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b1, 32'hE2821005, 1'b0);
        idle();
        // start while a session is open must not move the write pointer
        start = 1'b1; base_addr = 32'h800;
        @(posedge clk); #1;
        start = 1'b0;
        send(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 24'h000008, 1'b1, 32'hE5903008, 1'b0);
        send(4'hE, 2'b10, 6'b100000, 4'd0, 4'd0, 24'hFFFFFE, 1'b1, 32'hEAFFFFFE, 1'b0);
        idle();
        finish_pulse();
        wait_done("legal");
        check_end("legal", 7'd3, 1'b0);
    endtask

    task automatic test_illegal_mix();
        sel = 0;
        start_session(32'h203);
        send(4'hE, 2'b00, 6'b000101, 4'd1, 4'd2, 24'h000003, 1'b1, 32'hE0512003, 1'b0);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL illegal_ready got=%b required=1", s_ready); end
        send(4'hE, 2'b11, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b0, 32'h0, 1'b0);
        checks++;
        if (s_ready !== 1'b1 || s_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_op ready=%b err=%b required ready=1 err=1", s_ready, s_err);
        end
        send(4'hF, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b0, 32'h0, 1'b0);
        send(4'hE, 2'b00, 6'b000010, 4'd2, 4'd1, 24'h000005, 1'b0, 32'h0, 1'b0);
        send(4'hE, 2'b10, 6'b000000, 4'd0, 4'd0, 24'h000010, 1'b0, 32'h0, 1'b0);
        checks++;
        if (s_ready !== 1'b1 || s_count !== 7'd1) begin
            failures++;
            $display("FAIL illegal_hold ready=%b count=%0d required ready=1 count=1", s_ready, s_count);
        end
        idle();
        finish_pulse();
        wait_done("illegal");
        check_end("illegal", 7'd1, 1'b1);
    endtask

    task automatic test_capacity();
        int acc;
        sel = 1;
        acc = 0;
        start_session(32'h40);
        in_valid = 1'b1; in_cond = 4'hE; in_op = 2'b00; in_funct = 6'b101000;
        in_rn = 4'd2; in_rd = 4'd1;
        for (int i = 0; i < 6; i++) begin
            in_imm = 24'(i);
            @(negedge clk);
            if (c_ready) begin
                push_exp(32'hE2821000 | 32'(i));
                acc++;
            end
            @(posedge clk); #1;
            if (acc == 4) begin
                checks++;
                if (c_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL capacity_ready beat=%0d in_ready=%b required=0", i, c_ready);
                end
            end
        end
        idle();
        checks++;
        if (acc != 4) begin failures++; $display("FAIL capacity_accepts got=%0d required=4", acc); end
        wait_done("capacity");
        check_end("capacity", 7'd4, 1'b0);
        finish_pulse();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_valid_finish();
        sel = 0;
        start_session(32'h300);
        send(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0, 24'h0, 1'b0, 32'h0, 1'b0);
        send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000007, 1'b1, 32'hE2821007, 1'b1);
        idle();
        wait_done("valid_finish");
        check_end("valid_finish", 7'd1, 1'b1);
        start_session(32'h400);
        send(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 24'h000008, 1'b1, 32'hE5903008, 1'b0);
        idle();
        finish_pulse();
        wait_done("restart");
        check_end("restart", 7'd1, 1'b0);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        start_session(32'h500);
        send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000009, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        idle();
        #2;
        checks++;
        if ({m_we, m_addr, m_wdata, m_busy, m_done, m_err, m_count, m_ready} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async we=%b addr=%h data=%h busy=%b done=%b err=%b count=%0d ready=%b required all 0",
                     m_we, m_addr, m_wdata, m_busy, m_done, m_err, m_count, m_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start_session(32'h600);
        send(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 24'h000008, 1'b1, 32'hE5903008, 1'b0);
        idle();
        finish_pulse();
        wait_done("after_reset");
        check_end("after_reset", 7'd1, 1'b0);
    endtask

    task automatic test_wrap();
        sel = 2;
        start_session(32'hFC);
        send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000001, 1'b1, 32'hE2821001, 1'b0);
        send(4'hE, 2'b01, 6'b011001, 4'd0, 4'd3, 24'h000008, 1'b1, 32'hE5903008, 1'b0);
        idle();
        finish_pulse();
        wait_done("wrap");
        check_end("wrap", 7'd2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_legal_mix();
        test_illegal_mix();
        test_capacity();
        test_valid_finish();
        test_reset_mid();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's instruction decoder.
- Accepts decoded instruction fields (cond/op/funct/rn/rd/imm) over a valid/ready stream and packs them into 32-bit ARM-subset instruction words.
- Writes the words sequentially into instruction memory from a programmable base address.
- Used by the test/boot infrastructure to load programs without a pre-built hex image; rejects encodings the core cannot execute.

Parameters:
- ADDR_W, 32, instruction-memory byte-address width.
- DEPTH, 64, maximum words written per load session.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that opens a load session.
- base_addr  in  ADDR_W  word-aligned start address, sampled on start.
- finish  in  1  pulse that closes the session.
- in_valid  in  1  field beat valid.
- in_ready  out  1  block can accept a beat.
- in_cond  in  4  condition field.
- in_op  in  2  op field: 00 DP, 01 MEM, 10 B.
- in_funct  in  6  funct field, bits 25:20.
- in_rn  in  4  Rn.
- in_rd  in  4  Rd.
- in_imm  in  24  src2 in [11:0] for DP/MEM; imm24 for B.
- imem_we  out  1  memory write strobe.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  encoded word.
- busy  out  1  session open.
- done  out  1  session closed; held until the next start.
- err  out  1  sticky flag: at least one illegal beat this session.
- word_count  out  $clog2(DEPTH+1)  words written this session.

Behaviour:
- Reset (asynchronous, takes effect mid-operation):
  - All outputs go to 0; state = IDLE; any pending write is discarded.
- States:
  - IDLE: in_ready=0. start -> RUN; base_addr latched; word_count, err and done cleared.
  - RUN: busy=1. in_ready = (word_count + pending < DEPTH).
    - finish -> DRAIN.
    - Last legal write bringing word_count to DEPTH -> DRAIN.
    - start is ignored.
  - DRAIN: in_ready=0. Waits one cycle so any registered write completes, then -> DONE.
  - DONE: done=1, busy=0. start -> RUN, as from IDLE.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - in_valid and finish in the same cycle: the beat is accepted first, then the session closes.
- Encoding, combinational from the beat, registered into the output stage:
  - DP: {cond, 2'b00, funct[5:0], rn, rd, imm[11:0]}.
  - MEM: {cond, 2'b01, funct[5:0], rn, rd, imm[11:0]}.
  - B: {cond, 2'b10, funct[5:4], imm[23:0]}.
- Illegal beats are still accepted but not written. err is set; word_count is unchanged. A beat is illegal if any of:
  - op==11.
  - cond==1111.
  - DP with funct[4:1] not in {ADD 0100, SUB 0010, AND 0000, ORR 1100}.
  - B with funct[5:4] != 10.
- Latency:
  - A legal beat accepted in cycle N produces imem_we=1 in cycle N+1.
  - imem_addr = base + 4*word_count (pre-increment value); word_count increments in N+1.
  - imem_we is a 1-cycle pulse per word. Back-to-back beats give back-to-back writes.
- Address arithmetic:
  - Modulo 2^ADDR_W; wrap is silent.
  - base_addr[1:0] forced to 00.
- imem_wdata and imem_addr hold their last value when imem_we=0.

Decomposition:
- Shared package inst_pkg, shared with the decoder:
  - OP_CODE_DP/MEM/B.
  - FUNCT_4_1_ADD/SUB/AND/ORR.
  - FUNCT_0_LDR/STR and FUNCT_5_DP_REG.
  - COND_AL and COND_NV (1111).
  - Loader state enum.
- One sub-module, instr_packer: purely combinational. Fields in -> {word, illegal}. Unit-testable against the decoder.

Test Plan:
- Legal mix, DEPTH=64:
  - stimulus: start, base_addr=0x100; beats ADD R1,R2,#5 (cond E, op 00, funct 101000, rn 2, rd 1, imm 005), then LDR R3,[R0,#8] (op 01, funct 011001, rn 0, rd 3, imm 008), then B imm FFFFFE (op 10, funct 10xxxx); finish.
  - response: writes 0xE2821005@0x100, 0xE5903008@0x104, 0xEAFFFFFE@0x108, each 1 cycle after acceptance; word_count=3; done=1; err=0.
- Illegal mix:
  - stimulus: SUBS R2,R1,R3 (funct 000101, rn 1, rd 2, imm 003), then a beat with op=11, then one with cond=1111.
  - response: only 0xE0512003 written; word_count=1; err=1; in_ready stays high throughout.
- Capacity, DEPTH=4:
  - stimulus: 6 consecutive valid legal beats.
  - response: 4 writes; in_ready drops after the 4th acceptance; done asserts with word_count=4 and no finish needed.
- Simultaneous valid+finish:
  - response: that beat is written; then done.
  - follow-up: start again -> done, err and word_count cleared; new base_addr used.
- Reset mid-session:
  - stimulus: rst asserted the cycle after an accepted beat.
  - response: no imem_we pulse; all outputs 0.
  - follow-up: start works normally after reset.
- Address wrap:
  - stimulus: ADDR_W=8, base_addr=0xFC, 2 beats.
  - response: addresses 0xFC then 0x00.
